line_raster_engine: RTL and testbench

- Parametrised successor to the current line/flip draw path: a Bresenham line rasteriser that turns one endpoint pair plus colour into a stream of frame-buffer pixel writes, one pixel per cycle.
- Generalised in coordinate width, frame geometry, address width and colour depth.
- Adds frame clipping and a write stall input that the current line drawer lacks.
- Sits between the command decoder (go/done handshake) and the frame controller write port.

---
 rtl/line_raster_engine.sv | 188 ++++++++++++++++++
 tb/tb_line_raster_engine.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/line_raster_engine.sv
`default_nettype none
// ============================================================================
// Module   : line_raster_engine
// Purpose  : Bresenham line rasteriser. Converts one endpoint pair plus a
//            colour into a stream of frame-buffer pixel writes, one pixel per
//            non-stalled cycle, with frame clipping and a write-stall input.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module line_raster_engine #(
  parameter int COORD_W = 8,
  parameter int FRAME_W = 240,
  parameter int FRAME_H = 160,
  parameter int ADR_W   = 16,
  parameter int COLOR_W = 9
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iGo,
  input  logic [COORD_W-1:0] iX0,
  input  logic [COORD_W-1:0] iY0,
  input  logic [COORD_W-1:0] iX1,
  input  logic [COORD_W-1:0] iY1,
  input  logic [COLOR_W-1:0] iColor,
  input  logic               iStall,
  output logic               oDone,
  output logic               oWrEn,
  output logic [ADR_W-1:0]   oAdr,
  output logic [COLOR_W-1:0] oColor
);

  // Error term width: wide enough that dx-dy and every update stay in range.
  localparam int EW = COORD_W + 2;
  localparam logic [COORD_W-1:0] C_ONE     = COORD_W'(1);
  localparam logic [ADR_W-1:0]   C_STRIDE  = ADR_W'(FRAME_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [COORD_W-1:0]    x0_q, x0_d, y0_q, y0_d;
  logic [COORD_W-1:0]    x1_q, x1_d, y1_q, y1_d;
  logic [COORD_W-1:0]    x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0]    dx_q, dx_d, dy_q, dy_d;
  logic                  sxn_q, sxn_d, syn_q, syn_d;
  logic signed [EW-1:0]  err_q, err_d;
  logic                  done_q, done_d;
  logic                  wren_q, wren_d;
  logic [ADR_W-1:0]      adr_q, adr_d;
  logic [COLOR_W-1:0]    color_q, color_d;

  // Step decision operands, one bit wider than err so 2*err cannot overflow.
  logic signed [EW:0]    e2;
  logic signed [EW:0]    dx_e;
  logic signed [EW:0]    dy_e;
  logic signed [EW:0]    err_t;
  logic                  in_frame;
  logic                  at_end;
  logic [ADR_W-1:0]      pix_adr;

  assign e2       = $signed({err_q, 1'b0});
  assign dx_e     = $signed({3'b000, dx_q});
  assign dy_e     = $signed({3'b000, dy_q});
  assign in_frame = (32'(x_q) < FRAME_W) && (32'(y_q) < FRAME_H);
  assign at_end   = (x_q == x1_q) && (y_q == y1_q);
  assign pix_adr  = ADR_W'(y_q) * C_STRIDE + ADR_W'(x_q);

  assign oDone  = done_q;
  assign oWrEn  = wren_q;
  assign oAdr   = adr_q;
  assign oColor = color_q;

  // Next-state, stepping and output-stage logic for the rasteriser FSM.
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    sxn_d   = sxn_q;
    syn_d   = syn_q;
    err_d   = err_q;
    done_d  = done_q;
    wren_d  = 1'b0;
    adr_d   = adr_q;
    color_d = color_q;
    err_t   = {err_q[EW-1], err_q};

    case (state_q)
      IDLE: begin
        done_d = 1'b1;
        // Only a go seen while oDone is already high starts a line.
        if (iGo && done_q) begin
          x0_d    = iX0;
          y0_d    = iY0;
          x1_d    = iX1;
          y1_d    = iY1;
          color_d = iColor;
          done_d  = 1'b0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        dx_d    = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
        dy_d    = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
        sxn_d   = (x1_q < x0_q);
        syn_d   = (y1_q < y0_q);
        err_d   = $signed({2'b00, dx_d}) - $signed({2'b00, dy_d});
        x_d     = x0_q;
        y_d     = y0_q;
        state_d = DRAW;
      end

      DRAW: begin
        if (!iStall) begin
          // Clipped points are iterated but never strobed.
          wren_d = in_frame;
          adr_d  = pix_adr;
          if (at_end) begin
            state_d = IDLE;
          end else begin
            if (e2 > -dy_e) begin
              err_t = err_t - dy_e;
              x_d   = sxn_q ? (x_q - C_ONE) : (x_q + C_ONE);
            end
            if (e2 < dx_e) begin
              err_t = err_t + dx_e;
              y_d   = syn_q ? (y_q - C_ONE) : (y_q + C_ONE);
            end
            err_d = err_t[EW-1:0];
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any line in progress.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      sxn_q   <= 1'b0;
      syn_q   <= 1'b0;
      err_q   <= '0;
      done_q  <= 1'b1;
      wren_q  <= 1'b0;
      adr_q   <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sxn_q   <= sxn_d;
      syn_q   <= syn_d;
      err_q   <= err_d;
      done_q  <= done_d;
      wren_q  <= wren_d;
      adr_q   <= adr_d;
      color_q <= color_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_line_raster_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_raster_engine
// Purpose  : Self-checking bench for line_raster_engine against a plain
//            Bresenham point-list model with directed and random lines.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_raster_engine;

  localparam int CW = 8;
  localparam int FW = 240;
  localparam int FH = 160;
  localparam int AW = 16;
  localparam int KW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [CW-1:0] x0, y0, x1, y1;
  logic [KW-1:0] color;
  logic          stall;
  logic          done;
  logic          wren;
  logic [AW-1:0] adr;
  logic [KW-1:0] ocolor;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  line_raster_engine #(
    .COORD_W(CW), .FRAME_W(FW), .FRAME_H(FH), .ADR_W(AW), .COLOR_W(KW)
  ) dut (
    .iClk(clk), .iRst(rst), .iGo(go),
    .iX0(x0), .iY0(y0), .iX1(x1), .iY1(y1),
    .iColor(color), .iStall(stall),
    .oDone(done), .oWrEn(wren), .oAdr(adr), .oColor(ocolor)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // stall_mode: 0 none, 1 random, 2 three cycles after the 2nd write.
  // rst_at: pulse reset after that many writes (0 = never).
  // noise: throw ignored go pulses with junk operands during the line.
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int col, input int stall_mode, input int rst_at,
                          input bit noise);
    int  px[$];
    int  py[$];
    int  ddx, ddy, ssx, ssy, err, e2x, cx, cy;
    int  p, writes, stall_cnt, exp_a;
    bit  exp_w, s, stalled_once;

    // Reference point list straight from the Bresenham rules.
    ddx = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
    ddy = (ay1 >= ay0) ? ay1 - ay0 : ay0 - ay1;
    ssx = (ax1 >= ax0) ? 1 : -1;
    ssy = (ay1 >= ay0) ? 1 : -1;
    err = ddx - ddy;
    cx  = ax0;
    cy  = ay0;
    forever begin
      px.push_back(cx);
      py.push_back(cy);
      if (cx == ax1 && cy == ay1) break;
      e2x = 2 * err;
      if (e2x > -ddy) begin err -= ddy; cx += ssx; end
      if (e2x < ddx)  begin err += ddx; cy += ssy; end
    end

    @(negedge clk);
    for (int i = 0; i < 600 && !done; i++) @(negedge clk);
    check("idle_done", done, 1);

    x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
    color = KW'(col);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("setup_done", done, 0);
    check("setup_wren", wren, 0);
    stall = (stall_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;

    exp_w = 1'b0; exp_a = 0; p = 0; writes = 0; stall_cnt = 0; stalled_once = 1'b0;
    forever begin
      @(negedge clk);
      go = 1'b0;
      check("wren", wren, exp_w);
      if (exp_w) begin
        check("adr", adr, exp_a);
        check("color", ocolor, col);
        writes++;
      end
      check("busy", done, 0);
      if (rst_at > 0 && writes == rst_at) begin
        rst = 1'b1; stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_wren", wren, 0);
        check("rst_done", done, 1);
        check("rst_adr", adr, 0);
        check("rst_color", ocolor, 0);
        repeat (10) begin
          @(negedge clk);
          check("post_rst_wren", wren, 0);
        end
        return;
      end
      if (p == px.size()) break;
      if (stall_mode == 2 && writes == 2 && !stalled_once) begin
        stall_cnt = 3; stalled_once = 1'b1;
      end
      if (stall_cnt > 0) begin
        s = 1'b1; stall_cnt--;
      end else begin
        s = (stall_mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      stall = s;
      if (noise && $urandom_range(0, 5) == 0) begin
        go = 1'b1;
        x0 = CW'($urandom); y0 = CW'($urandom);
        x1 = CW'($urandom); y1 = CW'($urandom);
        color = KW'($urandom);
      end
      if (s) begin
        exp_w = 1'b0;
      end else begin
        exp_w = (px[p] < FW) && (py[p] < FH);
        exp_a = py[p] * FW + px[p];
        p++;
      end
    end
    stall = 1'b0;
    go    = 1'b0;
    @(negedge clk);
    check("done_rise", done, 1);
    check("end_wren", wren, 0);
  endtask

  initial begin
    int rx0, ry0, rx1, ry1;
    rst = 1'b1; go = 1'b0; stall = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
    repeat (3) @(negedge clk);
    check("reset_done", done, 1);
    check("reset_wren", wren, 0);
    check("reset_adr", adr, 0);
    check("reset_color", ocolor, 0);
    rst = 1'b0;

    run_line(0, 0, 3, 0, 'h1FF, 0, 0, 1'b0);     // horizontal
    run_line(0, 0, 2, 2, 'h0A5, 0, 0, 1'b0);     // diagonal
    run_line(1, 3, 0, 0, 'h123, 0, 0, 1'b0);     // steep reverse
    run_line(5, 5, 5, 5, 'h0F0, 0, 0, 1'b0);     // single point
    run_line(238, 0, 241, 0, 'h111, 0, 0, 1'b0); // clipped tail
    run_line(0, 0, 3, 0, 'h1C3, 2, 0, 1'b0);     // stall after 2nd write
    run_line(0, 0, 9, 0, 'h055, 0, 0, 1'b1);     // go ignored while busy
    run_line(0, 0, 9, 0, 'h0AA, 0, 2, 1'b0);     // reset after 2 writes
    run_line(0, 0, 3, 0, 'h1FF, 0, 0, 1'b0);     // clean line after reset
    run_line(255, 255, 0, 0, 'h007, 1, 0, 1'b1); // full-range diagonal, clipped start

    repeat (40) begin
      if ($urandom_range(0, 1) == 1) begin
        rx0 = $urandom_range(0, 255); ry0 = $urandom_range(0, 255);
        rx1 = $urandom_range(0, 255); ry1 = $urandom_range(0, 255);
      end else begin
        rx0 = $urandom_range(200, 250); ry0 = $urandom_range(120, 170);
        rx1 = $urandom_range(200, 250); ry1 = $urandom_range(120, 170);
      end
      run_line(rx0, ry0, rx1, ry1, int'($urandom_range(0, 511)),
               int'($urandom_range(0, 1)), 0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
